// File: rtl/key_schedule_if.sv
// key_schedule_if: key-load handshake and round-key read bus of the key scheduler
interface key_schedule_if #(parameter int KEY_W = 128);
    logic             key_valid;
    logic             key_ready;
    logic [KEY_W-1:0] key_in;
    logic             rk_req;
    logic [3:0]       rk_addr;
    logic             rk_valid;
    logic [KEY_W-1:0] rk_data;
    logic             rk_err;
    logic             busy;
    logic             keys_ready;
    modport master (output key_valid, key_in, rk_req, rk_addr,
                    input  key_ready, rk_valid, rk_data, rk_err, busy, keys_ready);
    modport slave  (input  key_valid, key_in, rk_req, rk_addr,
                    output key_ready, rk_valid, rk_data, rk_err, busy, keys_ready);
endinterface

// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl: iterative AES-128 key expansion, one round key per clock into an indexed store
module key_schedule_ctrl #(
    parameter int NR    = 10,
    parameter int KEY_W = 128
) (
    input logic           clk,
    input logic           rst_n,
    key_schedule_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;
    localparam logic [3:0] LAST = 4'(NR);
    state_t           state;
    logic [3:0]       cnt;
    logic [7:0]       rcon;
    logic [15:0]      v;
    logic [KEY_W-1:0] cur;
    logic [KEY_W-1:0] nxt;
    logic [KEY_W-1:0] rk [0:NR];
    logic [31:0]      t;
    logic             accept;
    logic             rd_hit;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254, zero maps to zero) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] y;
        y = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            y = gmul(y, y);
            if (i != 0) y = gmul(y, a);
        end
        return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
    endfunction

    assign accept = bus.key_valid & bus.key_ready;
    assign rd_hit = bus.rk_req && bus.rk_addr <= LAST && v[bus.rk_addr];

    // shared expansion step applied to the previous round key held in cur
    always_comb begin
        t   = {sbox(cur[23:16]), sbox(cur[15:8]), sbox(cur[7:0]), sbox(cur[31:24])} ^ {rcon, 24'h0};
        nxt[127:96] = cur[127:96] ^ t;
        nxt[95:64]  = cur[95:64] ^ nxt[127:96];
        nxt[63:32]  = cur[63:32] ^ nxt[95:64];
        nxt[31:0]   = cur[31:0] ^ nxt[63:32];
    end

    // round-key store and working key; contents are qualified by v so no reset is needed
    always_ff @(posedge clk) begin
        if (accept) begin
            rk[0] <= bus.key_in;
            cur   <= bus.key_in;
        end else if (state == EXPAND) begin
            rk[cnt] <= nxt;
            cur     <= nxt;
        end
    end

    // sequencer FSM, valid bitmap and registered read port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            rcon           <= 8'h01;
            v              <= 16'h0;
            bus.key_ready  <= 1'b1;
            bus.busy       <= 1'b0;
            bus.keys_ready <= 1'b0;
            bus.rk_valid   <= 1'b0;
            bus.rk_err     <= 1'b0;
            bus.rk_data    <= '0;
        end else begin
            bus.rk_valid <= rd_hit;
            bus.rk_err   <= bus.rk_req && bus.rk_addr > LAST;
            if (rd_hit) bus.rk_data <= rk[bus.rk_addr];
            if (accept) begin
                state          <= EXPAND;
                cnt            <= 4'd1;
                rcon           <= 8'h01;
                v              <= 16'h1;
                bus.key_ready  <= 1'b0;
                bus.busy       <= 1'b1;
                bus.keys_ready <= 1'b0;
            end else if (state == EXPAND) begin
                v[cnt] <= 1'b1;
                cnt    <= cnt + 4'd1;
                rcon   <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                if (cnt == LAST) begin
                    state          <= READY;
                    bus.key_ready  <= 1'b1;
                    bus.busy       <= 1'b0;
                    bus.keys_ready <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// tb_key_schedule_ctrl: directed vectors with a response scoreboard for key_schedule_ctrl
module tb_key_schedule_ctrl;
    typedef struct {
        logic         err;
        logic [127:0] data;
        string        name;
    } exp_t;

    localparam logic [127:0] K1  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] K2  = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    localparam logic [127:0] R1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    localparam logic [127:0] R3  = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
    localparam logic [127:0] R10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
    localparam logic [127:0] Z1  = 128'h62636363_62636363_62636363_62636363;
    localparam logic [127:0] Z10 = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_schedule_if #(.KEY_W(128)) bus();
    key_schedule_ctrl #(.NR(10), .KEY_W(128)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic rd(input logic [3:0] a, input logic err, input logic [127:0] d, input string name);
        bus.rk_req  = 1'b1;
        bus.rk_addr = a;
        q.push_back('{err, d, name});
        step();
    endtask

    // monitor: every read response is popped and compared against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (bus.rk_valid || bus.rk_err)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: valid=%b err=%b expected no response", bus.rk_valid, bus.rk_err);
            end else begin
                e = q.pop_front();
                chk({e.name, "_flags"}, {126'h0, bus.rk_err, bus.rk_valid}, {126'h0, e.err, !e.err});
                if (!e.err) chk({e.name, "_data"}, bus.rk_data, e.data);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.key_valid = 1'b0;
        bus.key_in    = '0;
        bus.rk_req    = 1'b0;
        bus.rk_addr   = 4'd0;
        step();
        step();
        rst_n = 1'b1;
        at_neg();
        chk("rst_key_ready", bus.key_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_keys_ready", bus.keys_ready, 0);
        chk("rst_rk_valid", bus.rk_valid, 0);
        chk("rst_rk_err", bus.rk_err, 0);
        chk("rst_rk_data", bus.rk_data, 0);
        // FIPS-197 key, progressive read, back-pressure with a second key
        step();
        bus.key_valid = 1'b1;
        bus.key_in    = K1;
        at_neg();
        chk("accept_key_ready", bus.key_ready, 1);
        step();
        bus.key_in = K2;
        at_neg();
        chk("t1_busy", bus.busy, 1);
        chk("t1_key_ready", bus.key_ready, 0);
        step();
        step();
        bus.rk_req  = 1'b1;
        bus.rk_addr = 4'd3;
        step();
        q.push_back('{1'b0, R3, "progressive_idx3"});
        at_neg();
        chk("progressive_early_idx3", bus.rk_valid, 0);
        step();
        bus.rk_req = 1'b0;
        repeat (5) step();
        at_neg();
        chk("t10_busy", bus.busy, 1);
        chk("t10_keys_ready", bus.keys_ready, 0);
        step();
        bus.key_valid = 1'b0;
        at_neg();
        chk("t11_keys_ready", bus.keys_ready, 1);
        chk("t11_busy", bus.busy, 0);
        chk("t11_key_ready", bus.key_ready, 1);
        rd(4'd1, 1'b0, R1, "fips_idx1");
        rd(4'd10, 1'b0, R10, "fips_idx10");
        rd(4'd0, 1'b0, K1, "backpressure_idx0");
        bus.rk_req = 1'b0;
        step();
        step();
        // rekey from READY with a zero key and a same-cycle read of the old idx10
        bus.key_valid = 1'b1;
        bus.key_in    = '0;
        rd(4'd10, 1'b0, R10, "rekey_old_idx10");
        bus.key_valid = 1'b0;
        bus.rk_req    = 1'b1;
        bus.rk_addr   = 4'd10;
        step();
        bus.rk_req = 1'b0;
        at_neg();
        chk("rekey_idx10_cleared", bus.rk_valid, 0);
        repeat (9) step();
        at_neg();
        chk("rekey_keys_ready", bus.keys_ready, 1);
        rd(4'd10, 1'b0, Z10, "zero_idx10");
        rd(4'd1, 1'b0, Z1, "zero_idx1");
        // out-of-range indices
        rd(4'd11, 1'b1, '0, "oor_idx11");
        rd(4'd15, 1'b1, '0, "oor_idx15");
        bus.rk_req = 1'b0;
        step();
        at_neg();
        chk("oor_err_pulse_end", bus.rk_err, 0);
        chk("rk_data_hold", bus.rk_data, Z1);
        // reset in the middle of an expansion
        step();
        bus.key_valid = 1'b1;
        bus.key_in    = K1;
        step();
        bus.key_valid = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        at_neg();
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_keys_ready", bus.keys_ready, 0);
        chk("midrst_key_ready", bus.key_ready, 1);
        bus.rk_req  = 1'b1;
        bus.rk_addr = 4'd0;
        step();
        bus.rk_req = 1'b0;
        at_neg();
        chk("midrst_idx0_none", bus.rk_valid, 0);
        step();
        step();
        chk("scoreboard_drained", 128'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
